seq_mul5_ctrl: RTL

SEQ_MUL5_CTRL -- requirements
Module: seq_mul5_ctrl

---
 rtl/mul_pkg.sv | 13 +
 rtl/lf_add.sv | 49 ++++
 rtl/seq_mul5_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encodings and the default operand width.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W_DEFAULT = 5;

endpackage

// File: rtl/lf_add.sv
// W-bit Ladner-Fischer (minimum-depth / Sklansky form) prefix adder with carry-in
// and a W+1-bit sum; the only arithmetic resource of the multiplier.
module lf_add #(
    parameter int W = 5
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W:0]   s
);
    localparam int L = (W > 1) ? $clog2(W) : 1;
    localparam int IW = L;

    logic [W-1:0] hp;
    logic [W-1:0] g;
    logic [W-1:0] pp;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    logic [W-1:0] cvec;

    assign hp = x ^ y;

    always_comb begin
        g  = x & y;
        pp = hp;
        gn = '0;
        pn = '0;
        // Bit 0 absorbs the carry-in so every group generate already includes it.
        g[0] = (x[0] & y[0]) | (hp[0] & cin);
        for (int lv = 0; lv < L; lv++) begin
            gn = g;
            pn = pp;
            for (int i = 0; i < W; i++) begin
                if (((i >> lv) & 1) == 1) begin
                    int j;
                    j = ((i >> lv) << lv) - 1;
                    gn[i[IW-1:0]] = g[i[IW-1:0]] | (pp[i[IW-1:0]] & g[j[IW-1:0]]);
                    pn[i[IW-1:0]] = pp[i[IW-1:0]] & pp[j[IW-1:0]];
                end
            end
            g  = gn;
            pp = pn;
        end
    end

    assign cvec = {g[W-2:0], cin};
    assign s    = {g[W-1], hp ^ cvec};

endmodule

// File: rtl/seq_mul5_ctrl.sv
// Sequential W x W unsigned shift-add multiplier with valid/ready handshakes.
// Optional SEQ_MUL5_ZERO_BYPASS_EN: zero operands skip RUN and finish at once.
module seq_mul5_ctrl
    import mul_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);
    localparam int CW = $clog2(W);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   m_r;
    logic [W-1:0]   acc_r;
    logic [W-1:0]   q_r;
    logic [CW-1:0]  cnt_r;
    logic [2*W-1:0] p_r;

    logic           load;
    logic           step;
    logic           last;
    logic           zero_hit;
    logic [W-1:0]   addend;
    logic [W:0]     sum;
    logic [2*W-1:0] shifted;

    assign addend  = q_r[0] ? m_r : '0;
    assign shifted = {sum, q_r[W-1:1]};
    assign last    = (cnt_r == CW'(W - 1));
    assign p       = p_r;

    lf_add #(.W(W)) u_add (
        .x   (acc_r),
        .y   (addend),
        .cin (1'b0),
        .s   (sum)
    );

`ifdef SEQ_MUL5_ZERO_BYPASS_EN
    assign zero_hit = (a == '0) || (b == '0);
`else
    assign zero_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = zero_hit ? DONE : RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // in_ready stays low here, so a new pair is never taken on the release edge.
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r   <= '0;
            acc_r <= '0;
            q_r   <= '0;
            cnt_r <= '0;
            p_r   <= '0;
        end else if (load) begin
            m_r   <= a;
            q_r   <= b;
            acc_r <= '0;
            cnt_r <= '0;
            if (zero_hit) begin
                p_r <= '0;
            end
        end else if (step) begin
            // Carry out of the adder becomes the new MSB of A as {A,Q} shifts right.
            {acc_r, q_r} <= shifted;
            cnt_r        <= cnt_r + CW'(1);
            if (last) begin
                p_r <= shifted;
            end
        end
    end

endmodule
